ex_mem_register: RTL
====================

EX_MEM_REGISTER -- requirements
Module: ex_mem_register

Interface
REQ-001 SHALL have parameter NB_DATA, default 32, data/address width.
REQ-002 SHALL have parameter NB_REG_ADDR, default 5, register-file index width.
REQ-003 SHALL have port i_clock  input  1  sole clock, rising edge.
REQ-004 SHALL have port i_reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port i_alu_result  input  NB_DATA  execute-stage ALU result.
REQ-006 SHALL have port i_alu_zero  input  1  ALU zero flag.
REQ-007 SHALL have port i_store_data  input  NB_DATA  rt value for stores.
REQ-008 SHALL have port i_branch_target  input  NB_DATA  computed branch address.
REQ-009 SHALL have port i_write_reg  input  NB_REG_ADDR  destination register.
REQ-010 SHALL have port i_ctrl  input  4  {reg_write, mem_read, mem_write, mem_to_reg}.
REQ-011 SHALL have ports i_branch, i_branch_ne  input  1 each  BEQ / BNE request.
REQ-012 SHALL have ports i_valid, i_stall, i_flush  input  1 each  slot valid, hold, kill.
REQ-013 SHALL have outputs o_alu_result, o_store_data, o_branch_target  NB_DATA; o_write_reg  NB_REG_ADDR; o_ctrl  4; o_branch_taken, o_valid  1 -- registered copies.

Function
REQ-014 SHALL compute branch_taken = i_valid & ((i_branch & i_alu_zero) | (i_branch_ne & ~i_alu_zero)) before capture.
REQ-015 SHALL capture all inputs on the rising edge when not stalled and not flushed; latency exactly 1 cycle.
REQ-016 SHALL hold every output unchanged while i_stall=1 and i_flush=0.
REQ-017 SHALL, on i_flush=1, load a bubble next edge: o_valid=0, o_ctrl=0, o_branch_taken=0; data outputs are don't-care and SHALL be zeroed.
REQ-018 SHALL give priority i_reset > i_flush > i_stall > capture.
REQ-019 SHALL force o_ctrl=0 and o_branch_taken=0 whenever the captured i_valid=0.
REQ-020 SHALL force captured reg_write=0 when i_write_reg=0 (register $zero is never written).
REQ-021 SHALL perform no arithmetic other than REQ-014; widths pass through unchanged.

Reset
REQ-022 SHALL, on i_reset=1 at a rising edge, clear every output register to 0, regardless of i_stall/i_flush.
REQ-023 SHALL discard an in-flight capture when reset is asserted mid-operation; first capture occurs on the first edge with i_reset=0.

Configuration
REQ-024 SHALL compile, when macro EX_MEM_FORWARD_EN is defined, outputs o_fwd_en (1), o_fwd_reg (NB_REG_ADDR), o_fwd_data (NB_DATA), driven combinationally from registered state: o_fwd_en = o_valid & reg_write & ~mem_to_reg; o_fwd_reg = o_write_reg; o_fwd_data = o_alu_result.
REQ-025 SHALL, without EX_MEM_FORWARD_EN, omit those ports entirely; all other behaviour identical.

Structure
REQ-026 SHALL place NB_DATA/NB_REG_ADDR defaults and i_ctrl bit-index constants (CTRL_REG_WRITE=3, CTRL_MEM_READ=2, CTRL_MEM_WRITE=1, CTRL_MEM_TO_REG=0) in the shared pipeline package.
REQ-027 SHALL be a single flat module; the branch-resolution term of REQ-014 is a local function, not a sub-module.

Verification
REQ-028 Reset: drive all inputs nonzero, i_reset=1 one edge -> all outputs 0.
REQ-029 Capture: i_valid=1, i_alu_result=0x0000_0010, i_write_reg=8, i_ctrl=4'b1000 -> next cycle o_alu_result=0x10, o_write_reg=8, o_ctrl=4'b1000, o_valid=1.
REQ-030 Branch: i_branch=1, i_alu_zero=1 -> o_branch_taken=1; i_branch_ne=1, i_alu_zero=1 -> o_branch_taken=0; i_valid=0 with i_branch=1, i_alu_zero=1 -> o_branch_taken=0.
REQ-031 Stall/flush: capture 0xA, then i_stall=1 for 3 cycles with new input 0xB -> outputs stay 0xA; i_stall=1 and i_flush=1 together -> o_valid=0, o_ctrl=0.
REQ-032 $zero guard: i_write_reg=0, i_ctrl=4'b1000 -> o_ctrl=4'b0000.
REQ-033 Forwarding (EX_MEM_FORWARD_EN): capture i_write_reg=9, i_ctrl=4'b1000, result 0x1234 -> o_fwd_en=1, o_fwd_reg=9, o_fwd_data=0x1234; with i_ctrl=4'b1101 (load) -> o_fwd_en=0.

Source files
------------

// File: rtl/ex_mem_register_pkg.sv
// -----------------------------------------------------------------------------
// ex_mem_register_pkg
// Shared pipeline package for the EX/MEM pipeline register.
//   - Default data/address width and register-file index width.
//   - Width of the control bundle and the bit position of each control flag
//     inside it: {reg_write, mem_read, mem_write, mem_to_reg}.
// No ports (package only).
// -----------------------------------------------------------------------------
package ex_mem_register_pkg;

    localparam int NB_DATA_DEF     = 32;
    localparam int NB_REG_ADDR_DEF = 5;

    localparam int NB_CTRL         = 4;
    localparam int CTRL_REG_WRITE  = 3;
    localparam int CTRL_MEM_READ   = 2;
    localparam int CTRL_MEM_WRITE  = 1;
    localparam int CTRL_MEM_TO_REG = 0;

endpackage : ex_mem_register_pkg

// File: rtl/ex_mem_register_if.sv
// -----------------------------------------------------------------------------
// ex_mem_register_if
// Bundle of every signal crossing the EX/MEM boundary (clock and reset stay
// plain ports on the register itself).
//   i_*  : execute-stage results, control bundle and slot handshake
//          (i_valid, i_stall, i_flush) driven by the upstream stage.
//   o_*  : registered copies presented to the memory stage.
// Modports:
//   master : the side that drives i_* and consumes o_* (pipeline / testbench).
//   slave  : the EX/MEM register itself.
// Optional build macro: EX_MEM_FORWARD_EN adds o_fwd_en / o_fwd_reg /
// o_fwd_data, the forwarding view of the registered state.
// -----------------------------------------------------------------------------
interface ex_mem_register_if
    import ex_mem_register_pkg::*;
#(
    parameter int NB_DATA     = NB_DATA_DEF,
    parameter int NB_REG_ADDR = NB_REG_ADDR_DEF
);

    // Upstream (execute stage) side
    logic [NB_DATA-1:0]     i_alu_result;
    logic                   i_alu_zero;
    logic [NB_DATA-1:0]     i_store_data;
    logic [NB_DATA-1:0]     i_branch_target;
    logic [NB_REG_ADDR-1:0] i_write_reg;
    logic [NB_CTRL-1:0]     i_ctrl;
    logic                   i_branch;
    logic                   i_branch_ne;
    logic                   i_valid;
    logic                   i_stall;
    logic                   i_flush;

    // Downstream (memory stage) side
    logic [NB_DATA-1:0]     o_alu_result;
    logic [NB_DATA-1:0]     o_store_data;
    logic [NB_DATA-1:0]     o_branch_target;
    logic [NB_REG_ADDR-1:0] o_write_reg;
    logic [NB_CTRL-1:0]     o_ctrl;
    logic                   o_branch_taken;
    logic                   o_valid;
`ifdef EX_MEM_FORWARD_EN
    logic                   o_fwd_en;
    logic [NB_REG_ADDR-1:0] o_fwd_reg;
    logic [NB_DATA-1:0]     o_fwd_data;
`endif

    modport master (
        output i_alu_result, i_alu_zero, i_store_data, i_branch_target,
               i_write_reg, i_ctrl, i_branch, i_branch_ne,
               i_valid, i_stall, i_flush,
`ifdef EX_MEM_FORWARD_EN
        input  o_fwd_en, o_fwd_reg, o_fwd_data,
`endif
        input  o_alu_result, o_store_data, o_branch_target,
               o_write_reg, o_ctrl, o_branch_taken, o_valid
    );

    modport slave (
        input  i_alu_result, i_alu_zero, i_store_data, i_branch_target,
               i_write_reg, i_ctrl, i_branch, i_branch_ne,
               i_valid, i_stall, i_flush,
`ifdef EX_MEM_FORWARD_EN
        output o_fwd_en, o_fwd_reg, o_fwd_data,
`endif
        output o_alu_result, o_store_data, o_branch_target,
               o_write_reg, o_ctrl, o_branch_taken, o_valid
    );

endinterface : ex_mem_register_if

// File: rtl/ex_mem_register.sv
// -----------------------------------------------------------------------------
// ex_mem_register
// EX/MEM pipeline register with branch resolution, stall, flush and a
// register-$zero write guard.
// Ports:
//   i_clock : sole clock, rising edge.
//   i_reset : synchronous, active-high reset; clears every output register.
//   bus     : ex_mem_register_if.slave -- execute-stage inputs (i_*) and the
//             registered copies (o_*) seen by the memory stage.
// Priority at each rising edge: i_reset > i_flush > i_stall > capture.
// Optional build macro: EX_MEM_FORWARD_EN drives o_fwd_en / o_fwd_reg /
// o_fwd_data combinationally from the registered state; without it those
// signals do not exist.
// -----------------------------------------------------------------------------
module ex_mem_register
    import ex_mem_register_pkg::*;
#(
    parameter int NB_DATA     = NB_DATA_DEF,
    parameter int NB_REG_ADDR = NB_REG_ADDR_DEF
) (
    input  logic               i_clock,
    input  logic               i_reset,
    ex_mem_register_if.slave   bus
);

    // Branch resolution: a valid BEQ is taken on zero, a valid BNE on non-zero.
    function automatic logic branch_resolve(
        input logic valid,
        input logic branch,
        input logic branch_ne,
        input logic alu_zero
    );
        return valid & ((branch & alu_zero) | (branch_ne & ~alu_zero));
    endfunction

    logic [NB_DATA-1:0]     alu_result_d,    alu_result_q;
    logic [NB_DATA-1:0]     store_data_d,    store_data_q;
    logic [NB_DATA-1:0]     branch_target_d, branch_target_q;
    logic [NB_REG_ADDR-1:0] write_reg_d,     write_reg_q;
    logic [NB_CTRL-1:0]     ctrl_d,          ctrl_q;
    logic                   branch_taken_d,  branch_taken_q;
    logic                   valid_d,         valid_q;

    // Control bundle as it would be captured this cycle.
    logic [NB_CTRL-1:0]     ctrl_capture;

    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it
        // unassigned; otherwise a latch would be inferred.
        ctrl_capture = bus.i_ctrl;
        // Register $zero is hard-wired; never request a write to it.
        if (bus.i_write_reg == '0) begin
            ctrl_capture[CTRL_REG_WRITE] = 1'b0;
        end
        // An empty slot carries no side effects downstream.
        if (!bus.i_valid) begin
            ctrl_capture = '0;
        end

        alu_result_d    = alu_result_q;
        store_data_d    = store_data_q;
        branch_target_d = branch_target_q;
        write_reg_d     = write_reg_q;
        ctrl_d          = ctrl_q;
        branch_taken_d  = branch_taken_q;
        valid_d         = valid_q;

        if (bus.i_flush) begin
            // Bubble: data is don't-care downstream but zeroed for determinism.
            alu_result_d    = '0;
            store_data_d    = '0;
            branch_target_d = '0;
            write_reg_d     = '0;
            ctrl_d          = '0;
            branch_taken_d  = 1'b0;
            valid_d         = 1'b0;
        end else if (!bus.i_stall) begin
            alu_result_d    = bus.i_alu_result;
            store_data_d    = bus.i_store_data;
            branch_target_d = bus.i_branch_target;
            write_reg_d     = bus.i_write_reg;
            ctrl_d          = ctrl_capture;
            branch_taken_d  = branch_resolve(bus.i_valid, bus.i_branch,
                                             bus.i_branch_ne, bus.i_alu_zero);
            valid_d         = bus.i_valid;
        end
        // Stall: defaults already hold the current state.
    end

    always_ff @(posedge i_clock) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples its _d value from before the edge, independent of order.
        if (i_reset) begin
            // NOTE: the data registers are reset too, not just the control
            // bits, so every output reads 0 after reset.
            alu_result_q    <= '0;
            store_data_q    <= '0;
            branch_target_q <= '0;
            write_reg_q     <= '0;
            ctrl_q          <= '0;
            branch_taken_q  <= 1'b0;
            valid_q         <= 1'b0;
        end else begin
            alu_result_q    <= alu_result_d;
            store_data_q    <= store_data_d;
            branch_target_q <= branch_target_d;
            write_reg_q     <= write_reg_d;
            ctrl_q          <= ctrl_d;
            branch_taken_q  <= branch_taken_d;
            valid_q         <= valid_d;
        end
    end

    assign bus.o_alu_result    = alu_result_q;
    assign bus.o_store_data    = store_data_q;
    assign bus.o_branch_target = branch_target_q;
    assign bus.o_write_reg     = write_reg_q;
    assign bus.o_ctrl          = ctrl_q;
    assign bus.o_branch_taken  = branch_taken_q;
    assign bus.o_valid         = valid_q;

`ifdef EX_MEM_FORWARD_EN
    // Only ALU results can be forwarded from here; load data is not yet known.
    assign bus.o_fwd_en   = valid_q & ctrl_q[CTRL_REG_WRITE] & ~ctrl_q[CTRL_MEM_TO_REG];
    assign bus.o_fwd_reg  = write_reg_q;
    assign bus.o_fwd_data = alu_result_q;
`endif

endmodule : ex_mem_register
